// File: rtl/var_loc_pkg.sv
// Shared types for the variable location allocator: location kinds, FSM
// states and the registered response record.
package var_loc_pkg;

  // Response record fields are sized for the default allocator build
  // (8 registers, 16-bit RAM addresses).
  localparam int unsigned LOC_REG_IDX_W = 3;
  localparam int unsigned LOC_ADDR_W    = 16;

  typedef enum logic [1:0] {
    REG   = 2'd0,
    STACK = 2'd1,
    ADDR  = 2'd2,
    ERR   = 2'd3
  } loc_kind_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } alloc_state_e;

  typedef struct packed {
    loc_kind_e                kind;
    logic [LOC_REG_IDX_W-1:0] reg_idx;
    logic [LOC_ADDR_W-1:0]    addr;
  } alloc_rsp_t;

endpackage

// File: rtl/var_loc_reg_freelist.sv
// Free-register tracker: one bit per register (1 = free), lowest-index
// free register selection and a free count.
module var_loc_reg_freelist
  import var_loc_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  localparam int unsigned IDX_W = $clog2(NUM_REGS),
  localparam int unsigned CNT_W = $clog2(NUM_REGS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             alloc_en,
  input  logic             rel_en,
  input  logic [IDX_W-1:0] rel_idx,
  output logic             free_any,
  output logic [IDX_W-1:0] free_idx,
  output logic [CNT_W-1:0] free_cnt
);

  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic [NUM_REGS-1:0] rel_mask, alloc_mask;

  // Lowest free index wins; count the free bits.
  always_comb begin
    free_any = |mask_q;
    free_idx = '0;
    free_cnt = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask_q[i]) free_idx = IDX_W'(i);
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      free_cnt = free_cnt + CNT_W'(mask_q[i]);
    end
  end

  // Release is applied before the grant so a no-op release of the register
  // being granted in the same cycle leaves it allocated.
  always_comb begin
    rel_mask   = '0;
    alloc_mask = '0;
    if (rel_en)   rel_mask[rel_idx]    = 1'b1;
    if (alloc_en) alloc_mask[free_idx] = 1'b1;
    mask_d = clear ? '1 : ((mask_q | rel_mask) & ~alloc_mask);
  end

  // Free mask register; everything free out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mask_q <= '1;
    else     mask_q <= mask_d;
  end

endmodule

// File: rtl/var_location_allocator.sv
// Variable location allocator: decides whether each variable lives in a
// register, on the stack or at a fixed RAM address, one request per
// handshake, and tracks allocation state across one function scope.
// Build macro VAR_LOCATION_ALLOCATOR_STATS_EN adds saturating per-kind
// response counters (stat_*_cnt).
module var_location_allocator
  import var_loc_pkg::*;
#(
  parameter int unsigned       NUM_REGS    = 8,
  parameter int unsigned       REG_BYTES   = 4,
  parameter int unsigned       STACK_DEPTH = 16,
  parameter int unsigned       ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] RAM_BASE    = 16'h0100,
  parameter logic [ADDR_W-1:0] RAM_LIMIT   = 16'hFF00,
  localparam int unsigned REG_W   = $clog2(NUM_REGS),
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1),
  localparam int unsigned CNT_W   = $clog2(NUM_REGS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [7:0]         req_size,
  input  logic               req_fixed_ram,
  input  logic               req_fixed_stack,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_kind,
  output logic [REG_W-1:0]   rsp_reg,
  output logic [ADDR_W-1:0]  rsp_addr,
  input  logic               rel_valid,
  input  logic               rel_kind,
  input  logic [REG_W-1:0]   rel_reg,
  input  logic               scope_clear,
  output logic [DEPTH_W-1:0] stack_depth,
  output logic [CNT_W-1:0]   regs_free
`ifdef VAR_LOCATION_ALLOCATOR_STATS_EN
  ,
  output logic [15:0]        stat_reg_cnt,
  output logic [15:0]        stat_stack_cnt,
  output logic [15:0]        stat_addr_cnt,
  output logic [15:0]        stat_err_cnt
`endif
);

  alloc_state_e       state_q, state_d;
  alloc_rsp_t         rsp_q, rsp_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [ADDR_W-1:0]  ram_q, ram_d;

  logic               accept, clear, pop, push, grant_reg, to_ram, to_stack;
  logic               free_any, stack_room, ram_room, fits_reg;
  logic [REG_W-1:0]   free_idx;
  logic [CNT_W-1:0]   free_cnt;
  logic [7:0]         size_eff;
  logic [ADDR_W:0]    ram_sum;

  assign accept     = (state_q == IDLE) && req_valid;
  assign clear      = (state_q == IDLE) && scope_clear && !req_valid;
  assign pop        = rel_valid && rel_kind && !clear && (depth_q != '0);
  assign size_eff   = (req_size == 8'd0) ? 8'd1 : req_size;
  assign ram_sum    = {1'b0, ram_q} + (ADDR_W + 1)'(size_eff);
  assign ram_room   = ram_sum <= {1'b0, RAM_LIMIT};
  assign stack_room = depth_q < DEPTH_W'(STACK_DEPTH);
  assign fits_reg   = size_eff <= 8'(REG_BYTES);

  var_loc_reg_freelist #(.NUM_REGS(NUM_REGS)) u_freelist (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .alloc_en (grant_reg),
    .rel_en   (rel_valid && !rel_kind && !clear),
    .rel_idx  (rel_reg),
    .free_any (free_any),
    .free_idx (free_idx),
    .free_cnt (free_cnt)
  );

  // Next state and placement decision; all checks use pre-release state.
  always_comb begin
    state_d   = state_q;
    rsp_d     = rsp_q;
    ram_d     = ram_q;
    push      = 1'b0;
    grant_reg = 1'b0;
    to_ram    = 1'b0;
    to_stack  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d       = RESP;
          rsp_d.kind    = ERR;
          rsp_d.reg_idx = '0;
          rsp_d.addr    = '0;
          if (!(req_fixed_ram && req_fixed_stack)) begin
            if (req_fixed_ram)                to_ram = 1'b1;
            else if (req_fixed_stack)         to_stack = 1'b1;
            else if (fits_reg && free_any) begin
              rsp_d.kind    = REG;
              rsp_d.reg_idx = LOC_REG_IDX_W'(free_idx);
              grant_reg     = 1'b1;
            end
            else if (stack_room)              to_stack = 1'b1;
            else                              to_ram = 1'b1;
          end
          if (to_stack && stack_room) begin
            rsp_d.kind = STACK;
            rsp_d.addr = LOC_ADDR_W'(depth_q);
            push       = 1'b1;
          end
          if (to_ram && ram_room) begin
            rsp_d.kind = ADDR;
            rsp_d.addr = LOC_ADDR_W'(ram_q);
            ram_d      = ram_sum[ADDR_W-1:0];
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear) ram_d = RAM_BASE;
  end

  // Stack depth: push and pop in the same cycle cancel out.
  always_comb begin
    depth_d = depth_q;
    if (clear)             depth_d = '0;
    else if (push && !pop) depth_d = depth_q + DEPTH_W'(1);
    else if (!push && pop) depth_d = depth_q - DEPTH_W'(1);
  end

  // State, response and allocation pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rsp_q   <= '0;
      depth_q <= '0;
      ram_q   <= RAM_BASE;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      depth_q <= depth_d;
      ram_q   <= ram_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_kind    = rsp_q.kind;
  assign rsp_reg     = REG_W'(rsp_q.reg_idx);
  assign rsp_addr    = ADDR_W'(rsp_q.addr);
  assign stack_depth = depth_q;
  assign regs_free   = free_cnt;

`ifdef VAR_LOCATION_ALLOCATOR_STATS_EN
  logic [15:0] stat_q [4];

  // Saturating per-kind counters, bumped on each response handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) stat_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < 4; i++) stat_q[i] <= '0;
    end else if (rsp_valid && rsp_ready && (stat_q[rsp_q.kind] != 16'hFFFF)) begin
      stat_q[rsp_q.kind] <= stat_q[rsp_q.kind] + 16'd1;
    end
  end

  assign stat_reg_cnt   = stat_q[0];
  assign stat_stack_cnt = stat_q[1];
  assign stat_addr_cnt  = stat_q[2];
  assign stat_err_cnt   = stat_q[3];
`endif

endmodule

// File: tb/tb_var_location_allocator.sv
// Self-checking bench for var_location_allocator: directed scenarios with
// literal expectations plus randomized traffic, all checked every cycle
// against a behavioural model of the placement rules.
module tb_var_location_allocator;

  localparam int NREG     = 8;
  localparam int RBYTES   = 4;
  localparam int SDEPTH   = 16;
  localparam int RAM_BASE = 'h0100;
  localparam int RAM_LIM  = 'hFF00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_fixed_ram = 1'b0, req_fixed_stack = 1'b0;
  logic [7:0]  req_size = 8'd0;
  logic        rsp_ready = 1'b1;
  logic        rel_valid = 1'b0, rel_kind = 1'b0, scope_clear = 1'b0;
  logic [2:0]  rel_reg = 3'd0;
  logic        req_ready, rsp_valid;
  logic [1:0]  rsp_kind;
  logic [2:0]  rsp_reg;
  logic [15:0] rsp_addr;
  logic [4:0]  stack_depth;
  logic [3:0]  regs_free;
`ifdef VAR_LOCATION_ALLOCATOR_STATS_EN
  logic [15:0] stat_reg_cnt, stat_stack_cnt, stat_addr_cnt, stat_err_cnt;
`endif

  int nchk = 0;
  int nfail = 0;

  var_location_allocator dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_size        (req_size),
    .req_fixed_ram   (req_fixed_ram),
    .req_fixed_stack (req_fixed_stack),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_kind        (rsp_kind),
    .rsp_reg         (rsp_reg),
    .rsp_addr        (rsp_addr),
    .rel_valid       (rel_valid),
    .rel_kind        (rel_kind),
    .rel_reg         (rel_reg),
    .scope_clear     (scope_clear),
    .stack_depth     (stack_depth),
    .regs_free       (regs_free)
`ifdef VAR_LOCATION_ALLOCATOR_STATS_EN
    ,
    .stat_reg_cnt    (stat_reg_cnt),
    .stat_stack_cnt  (stat_stack_cnt),
    .stat_addr_cnt   (stat_addr_cnt),
    .stat_err_cnt    (stat_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        m_busy = 0;
  int        m_kind = 0, m_reg = 0, m_addr = 0;
  int        m_depth = 0;
  int        m_ram = RAM_BASE;
  bit [NREG-1:0] m_free = '1;

  task automatic model_step();
    bit acc, clr, pop, to_ram, to_stack;
    int sz, low, take, push, nram, k, r, a;
    acc  = !m_busy && req_valid;
    clr  = !m_busy && scope_clear && !req_valid;
    take = -1; push = 0; nram = m_ram; k = 3; r = 0; a = 0;
    if (acc) begin
      sz = (req_size == 0) ? 1 : int'(req_size);
      low = -1;
      for (int i = NREG - 1; i >= 0; i--) if (m_free[i]) low = i;
      to_ram = 0; to_stack = 0;
      if (req_fixed_ram && req_fixed_stack) k = 3;
      else if (req_fixed_ram) to_ram = 1;
      else if (req_fixed_stack) to_stack = 1;
      else if (sz <= RBYTES && low >= 0) begin k = 0; r = low; take = low; end
      else if (m_depth < SDEPTH) to_stack = 1;
      else to_ram = 1;
      if (to_stack && m_depth < SDEPTH) begin k = 1; a = m_depth; push = 1; end
      if (to_ram && (m_ram + sz <= RAM_LIM)) begin k = 2; a = m_ram; nram = m_ram + sz; end
    end
    if (clr) begin
      m_free = '1; m_depth = 0; m_ram = RAM_BASE;
    end else begin
      pop = rel_valid && rel_kind && (m_depth > 0);
      if (rel_valid && !rel_kind) m_free[rel_reg] = 1'b1;
      if (take >= 0) m_free[take] = 1'b0;
      m_depth = m_depth + push - (pop ? 1 : 0);
      m_ram = nram;
    end
    if (acc) begin
      m_busy = 1; m_kind = k; m_reg = r; m_addr = a;
    end else if (m_busy && rsp_ready) begin
      m_busy = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_free = '1; m_depth = 0; m_ram = RAM_BASE;
    end else begin
      model_step();
    end
  end

  // Compare DUT against model on every falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", req_ready, !m_busy);
      chk("rsp_valid", rsp_valid, m_busy);
      chk("regs_free", regs_free, $countones(m_free));
      chk("stack_depth", stack_depth, m_depth);
      if (m_busy) begin
        chk("rsp_kind", rsp_kind, m_kind);
        chk("rsp_reg", rsp_reg, m_reg);
        chk("rsp_addr", rsp_addr, m_addr);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_req(output int k, output int r, output int a, input int sz,
                        input bit fr = 0, input bit fs = 0, input int hold = 0,
                        input bit relv = 0, input bit relk = 0, input int relr = 0);
    bit got;
    @(negedge clk);
    req_valid = 1; req_size = 8'(sz); req_fixed_ram = fr; req_fixed_stack = fs;
    rsp_ready = (hold == 0);
    rel_valid = relv; rel_kind = relk; rel_reg = 3'(relr);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rel_valid = 0;
      if (rsp_valid) begin got = 1; break; end
    end
    req_valid = 0;
    if (!got) chk("rsp_timeout", 0, 1);
    k = int'(rsp_kind); r = int'(rsp_reg); a = int'(rsp_addr);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_kind", rsp_kind, k);
      chk("hold_addr", rsp_addr, a);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_ready", req_ready, 0);
    end
    rsp_ready = 1;
  endtask

  task automatic do_rel(input bit kind, input int idx);
    @(negedge clk);
    rel_valid = 1; rel_kind = kind; rel_reg = 3'(idx);
    @(negedge clk);
    rel_valid = 0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    scope_clear = 1;
    @(negedge clk);
    scope_clear = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, r, a;

    // Reset values
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_kind", rsp_kind, 0);
    chk("reset_rsp_reg", rsp_reg, 0);
    chk("reset_rsp_addr", rsp_addr, 0);
    chk("reset_regs_free", regs_free, 8);
    chk("reset_stack_depth", stack_depth, 0);
    rst = 0;
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1);

    // Fill registers in order, ninth spills to stack slot 0
    for (int i = 0; i < 8; i++) begin
      do_req(k, r, a, 4);
      chk("fill_kind", k, 0);
      chk("fill_reg", r, i);
    end
    do_req(k, r, a, 4);
    chk("spill_kind", k, 1);
    chk("spill_addr", a, 0);
    chk("spill_regs_free", regs_free, 0);
    chk("spill_depth", stack_depth, 1);

    // Pop, then an oversized variable goes to stack slot 0; two fixed RAM
    do_rel(1, 0);
    chk("pop_depth", stack_depth, 0);
    do_req(k, r, a, 8);
    chk("big_kind", k, 1);
    chk("big_addr", a, 0);
    do_req(k, r, a, 16, 1, 0);
    chk("ram1_kind", k, 2);
    chk("ram1_addr", a, 'h0100);
    do_req(k, r, a, 16, 1, 0);
    chk("ram2_addr", a, 'h0110);

    // Conflicting flags, stack full
    do_req(k, r, a, 4, 1, 1);
    chk("both_kind", k, 3);
    chk("both_addr", a, 0);
    for (int i = 1; i < 16; i++) begin
      do_req(k, r, a, 2, 0, 1);
      chk("stk_addr", a, i);
    end
    do_req(k, r, a, 2, 0, 1);
    chk("stk_full_kind", k, 3);
    chk("stk_full_depth", stack_depth, 16);
    do_req(k, r, a, 4);
    chk("overflow_kind", k, 2);
    chk("overflow_addr", a, 'h0120);
    do_req(k, r, a, 0);
    chk("size0_addr", a, 'h0124);

    // RAM limit boundary
    do_clear();
    chk("clear_regs", regs_free, 8);
    chk("clear_depth", stack_depth, 0);
    do_rel(1, 0);
    chk("pop_empty_depth", stack_depth, 0);
    for (int i = 0; i < 254; i++) do_req(k, r, a, 255, 1, 0);
    do_req(k, r, a, 250, 1, 0);
    chk("ramfill_addr", a, 'hFE02);
    do_req(k, r, a, 8, 1, 0);
    chk("ramlim_err_kind", k, 3);
    chk("ramlim_err_addr", a, 0);
    do_req(k, r, a, 4, 1, 0);
    chk("ramlim_exact_kind", k, 2);
    chk("ramlim_exact_addr", a, 'hFEFC);
    do_req(k, r, a, 0, 1, 0);
    chk("ramlim_size0_kind", k, 3);

    // Hold with rsp_ready low; same-cycle release uses old mask
    do_clear();
    for (int i = 0; i < 8; i++) begin
      do_req(k, r, a, 1, 0, 0, (i == 2) ? 5 : 0);
      chk("refill_reg", r, i);
    end
    do_req(k, r, a, 2, 0, 0, 0, 1, 0, 3);
    chk("rel_same_kind", k, 1);
    chk("rel_same_addr", a, 0);
    do_req(k, r, a, 2);
    chk("rel_next_kind", k, 0);
    chk("rel_next_reg", r, 3);

    // scope_clear after mixed allocations
    do_clear();
    chk("clear2_regs", regs_free, 8);
    chk("clear2_depth", stack_depth, 0);
    do_req(k, r, a, 16, 1, 0);
    chk("clear2_ram", a, 'h0100);

    // Asynchronous reset while a response is pending
    @(negedge clk);
    rsp_ready = 0; req_valid = 1; req_size = 8'd1; req_fixed_ram = 0; req_fixed_stack = 0;
    @(negedge clk);
    req_valid = 0;
    chk("rst_pre_valid", rsp_valid, 1);
    #2 rst = 1;
    #1;
    chk("rst_async_valid", rsp_valid, 0);
    chk("rst_async_ready", req_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 0; rsp_ready = 1;
    @(negedge clk);
    chk("rst_after_regs", regs_free, 8);

    // Randomized traffic checked by the model
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      req_valid       = ($urandom_range(0, 1) == 1);
      req_size        = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      req_fixed_ram   = ($urandom_range(0, 9) == 0);
      req_fixed_stack = ($urandom_range(0, 9) == 0);
      rsp_ready       = ($urandom_range(0, 3) != 0);
      rel_valid       = ($urandom_range(0, 3) == 0);
      rel_kind        = ($urandom_range(0, 1) == 1);
      rel_reg         = 3'($urandom_range(0, 7));
      if (rel_kind && m_depth == 0 && req_valid && !m_busy) rel_valid = 0;
      scope_clear     = ($urandom_range(0, 49) == 0);
    end
    @(negedge clk);
    req_valid = 0; rel_valid = 0; scope_clear = 0; rsp_ready = 1;
    repeat (3) @(negedge clk);

`ifdef VAR_LOCATION_ALLOCATOR_STATS_EN
    do_clear();
    for (int i = 0; i < 3; i++) do_req(k, r, a, 1);
    for (int i = 0; i < 2; i++) do_req(k, r, a, 1, 0, 1);
    do_req(k, r, a, 4, 1, 0);
    do_req(k, r, a, 4, 1, 1);
    @(negedge clk);
    chk("stat_reg", stat_reg_cnt, 3);
    chk("stat_stack", stat_stack_cnt, 2);
    chk("stat_addr", stat_addr_cnt, 1);
    chk("stat_err", stat_err_cnt, 1);
    do_clear();
    chk("stat_clr_reg", stat_reg_cnt, 0);
    chk("stat_clr_stack", stat_stack_cnt, 0);
    chk("stat_clr_addr", stat_addr_cnt, 0);
    chk("stat_clr_err", stat_err_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/var_location_allocator.md
Name: var_location_allocator

Overview:
- Hardware location allocator for compiled variables.
- Takes one variable-placement request per handshake and decides where the variable lives:
  - register, when it fits and a register is free;
  - top of stack;
  - fixed RAM address.
- Downstream of the symbol front-end; feeds the location descriptor (register / stack / address) into the code emitter.
- Tracks the free register set, stack depth and RAM bump pointer across one function scope.

Parameters:
- NUM_REGS, 8, allocatable general registers (power of 2, ≥2).
- REG_BYTES, 4, max variable size (bytes) placeable in a register.
- STACK_DEPTH, 16, max live stack slots.
- ADDR_W, 16, RAM address width.
- RAM_BASE, 16'h0100, first RAM address allocated after reset/scope clear.
- RAM_LIMIT, 16'hFF00, first address beyond the allocatable RAM region.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  placement request valid
- req_ready  out  1  allocator can accept
- req_size  in  8  variable size in bytes (0 treated as 1)
- req_fixed_ram  in  1  variable must live in RAM
- req_fixed_stack  in  1  variable must live on stack
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_kind  out  2  0=REG, 1=STACK, 2=ADDR, 3=ERR
- rsp_reg  out  $clog2(NUM_REGS)  register index (REG only, else 0)
- rsp_addr  out  ADDR_W  stack slot index (STACK) or RAM address (ADDR), else 0
- rel_valid  in  1  release request
- rel_kind  in  1  0=register, 1=stack pop
- rel_reg  in  $clog2(NUM_REGS)  register to free
- scope_clear  in  1  new function scope: free all registers, empty stack, reset RAM pointer
- stack_depth  out  $clog2(STACK_DEPTH+1)  live stack slots
- regs_free  out  $clog2(NUM_REGS+1)  free register count

Behaviour:
- Reset (async, rst=1):
  - FSM=IDLE; all registers free; stack_depth=0; ram_ptr=RAM_BASE.
  - rsp_valid=0, rsp_kind=0, rsp_reg=0, rsp_addr=0, req_ready=1 after reset release.
  - Reset mid-transaction drops any pending response.
- FSM states:
  - IDLE: req_ready=1. On req_valid, evaluate placement and register the result; go to RESP next edge. Latency is 1 cycle: rsp_valid is high on the edge after acceptance.
  - RESP: req_ready=0; rsp_* held stable until rsp_valid&rsp_ready, then back to IDLE. Back-to-back throughput is 1 request per 2 cycles.
- Placement priority (first match wins):
  1. fixed_ram & fixed_stack → ERR; no state change.
  2. fixed_ram → ADDR.
  3. fixed_stack → STACK.
  4. size ≤ REG_BYTES and a free register exists → REG, lowest-index free register.
  5. stack_depth < STACK_DEPTH → STACK.
  6. Otherwise → ADDR.
- Allocation updates:
  - STACK: rsp_addr = stack_depth (before increment); stack_depth++. Full stack on forced STACK → ERR.
  - ADDR: rsp_addr = ram_ptr; ram_ptr += size, computed at ADDR_W+1 bits. If ram_ptr+size > RAM_LIMIT → ERR, ram_ptr unchanged.
  - ERR never modifies any allocation state.
- Release (any state, single cycle):
  - Register release frees rel_reg. Freeing an already-free register is a no-op.
  - Stack pop decrements stack_depth; pop at depth 0 is ignored.
  - An allocation in the same cycle uses the pre-release free mask and depth. Release updates take effect next cycle.
  - Same-cycle stack push and pop: net depth unchanged, and rsp_addr uses the old depth.
- scope_clear:
  - Honoured only in IDLE with no req_valid accepted that cycle. Takes priority over rel_valid.
  - In RESP it is ignored; the caller must re-assert it.
- regs_free and stack_depth are registered and reflect state after the last edge.

Optional Feature:
- Macro: VAR_LOCATION_ALLOCATOR_STATS_EN.
- Defined:
  - Adds outputs stat_reg_cnt, stat_stack_cnt, stat_addr_cnt, stat_err_cnt, each 16 bits, saturating.
  - Each counter increments on the response handshake of the matching kind.
  - Cleared by rst and by scope_clear.
- Undefined: ports and counters are absent.

Decomposition:
- Package var_loc_pkg:
  - loc_kind_e enum: REG, STACK, ADDR, ERR.
  - alloc_state_e: IDLE, RESP.
  - alloc_rsp_t struct: kind, reg, addr.
- Sub-module var_loc_reg_freelist:
  - NUM_REGS free mask, lowest-free priority encoder, popcount.
  - Alloc/release/clear inputs.

Test Plan:
- Reset, then 9 requests of size=4, no flags, rsp_ready=1 → regs 0..7 in order, then STACK addr 0; regs_free=0, stack_depth=1.
- Request size=8, no flags → STACK, rsp_addr=0. Then fixed_ram size=16 twice → ADDR 0x0100, then 0x0110.
- Both fixed flags set → ERR. Then fill stack to 16 and send fixed_stack → ERR with stack_depth=16. RAM at 0xFEFC, size=8 → ERR; ram_ptr unchanged.
- rsp_ready held low 5 cycles → rsp_* stable and req_ready=0 throughout. rel_valid reg=3 in same cycle as next accepted request with only reg3 free → request goes to STACK; reg3 is granted on the following request.
- scope_clear in IDLE after mixed allocations → regs_free=8, stack_depth=0, next fixed_ram → 0x0100. Assert rst during RESP → rsp_valid drops to 0 asynchronously.
- With STATS_EN: 3 REG, 2 STACK, 1 ADDR, 1 ERR handshakes → counters 3/2/1/1. scope_clear → all counters 0.
